fetch_pc_unit: RTL and testbench

//  IF-stage PC register, next-PC selector and IF/ID pipeline register of the 5-stage MIPS core.

---
 rtl/fetch_pc_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_pc_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: IF-stage PC register, next-PC selector and IF/ID register
// for the 5-stage delayed-branch MIPS core.
// Optional build macro PC_ALIGN_CHECK_EN adds the adel_d fetch-address
// error flag and suppresses the fetched word for illegal fetch addresses.

// Next-PC target computation. This block is purely combinational and has no state.
module fetch_npc (
  input  logic [31:0] pc_f,
  input  logic [31:0] pc_d,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic        bubble,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] rs_val,
  output logic [31:0] npc
);
  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_BR  = 2'b01;
  localparam logic [1:0] SEL_J   = 2'b10;
  localparam logic [1:0] SEL_JR  = 2'b11;

  logic [31:0] seq_t, br_t, j_t;

  assign seq_t = pc_f + 32'd4;
  assign br_t  = pc_d + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
  assign j_t   = {pc_d[31:28], instr_index, 2'b00};

  // Select the redirect. A bubble in ID has no valid control bits, so fetch goes sequential.
  always_comb begin
    npc = seq_t;
    if (!bubble) begin
      unique case (npc_sel)
        SEL_BR:  npc = br_taken ? br_t : seq_t;
        SEL_J:   npc = j_t;
        SEL_JR:  npc = rs_val;
        SEL_SEQ: npc = seq_t;
        default: npc = seq_t;
      endcase
    end
  end
endmodule

module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180,
  parameter logic [31:0] IMEM_LO  = 32'h0000_3000,
  parameter logic [31:0] IMEM_HI  = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] rs_val,
  input  logic [31:0] imem_instr,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic        adel_d
`endif
);

  // Redirect request bundle handed from the ID-stage decode to the selector.
  typedef struct packed {
    logic [1:0]  sel;
    logic        taken;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] rs;
  } redir_req_t;

  redir_req_t  req;
  logic [31:0] npc;
  logic        bubble;
  logic [31:0] fetch_word;

  assign req    = '{sel: npc_sel, taken: br_taken, imm: imm16, idx: instr_index, rs: rs_val};
  assign bubble = (instr_d == 32'd0);
  assign pc8_d  = pc_d + 32'd8;

  fetch_npc u_npc (
    .pc_f        (pc_f),
    .pc_d        (pc_d),
    .npc_sel     (req.sel),
    .br_taken    (req.taken),
    .bubble      (bubble),
    .imm16       (req.imm),
    .instr_index (req.idx),
    .rs_val      (req.rs),
    .npc         (npc)
  );

`ifdef PC_ALIGN_CHECK_EN
  logic adel_f;

  // Fetch address is illegal when misaligned or outside the instruction memory window.
  assign adel_f     = (pc_f[1:0] != 2'b00) || (pc_f < IMEM_LO) || (pc_f > IMEM_HI);
  assign fetch_word = adel_f ? 32'd0 : imem_instr;

  // Address-error flag travels with the IF/ID contents; cleared by the trap/return loads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    adel_d <= 1'b0;
    else if (exc_req || eret_req)  adel_d <= 1'b0;
    else if (!stall)               adel_d <= adel_f;
  end
`else
  assign fetch_word = imem_instr;
`endif

  // PC and IF/ID update. Trap and return squash the fetched word; stall freezes everything,
  // so a pending redirect is simply re-evaluated once the stall drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_f    <= RESET_PC;
      instr_d <= 32'd0;
      pc_d    <= 32'd0;
    end else if (exc_req) begin
      pc_f    <= EXC_PC;
      instr_d <= 32'd0;
      pc_d    <= pc_f;
    end else if (eret_req) begin
      pc_f    <= epc;
      instr_d <= 32'd0;
      pc_d    <= pc_f;
    end else if (!stall) begin
      pc_f    <= npc;
      instr_d <= fetch_word;
      pc_d    <= pc_f;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed bench for fetch_pc_unit with a reference model
// and per-cycle comparison, plus literal expectations at key points.
module tb_fetch_pc_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0, exc_req = 1'b0, eret_req = 1'b0, br_taken = 1'b0;
  logic [31:0] epc = 32'd0, rs_val = 32'd0;
  logic [1:0]  npc_sel = 2'b00;
  logic [15:0] imm16 = 16'd0;
  logic [25:0] instr_index = 26'd0;
  logic [31:0] imem_instr, pc_f, instr_d, pc_d, pc8_d;
`ifdef PC_ALIGN_CHECK_EN
  logic        adel_d;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  // Instruction memory contents: always non-zero so fetched words are never bubbles.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {8'h24, a[23:0]};
  endfunction

  assign imem_instr = imem_word(pc_f);

  fetch_pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .exc_req(exc_req), .eret_req(eret_req),
    .epc(epc), .npc_sel(npc_sel), .br_taken(br_taken), .imm16(imm16),
    .instr_index(instr_index), .rs_val(rs_val), .imem_instr(imem_instr),
    .pc_f(pc_f), .instr_d(instr_d), .pc_d(pc_d), .pc8_d(pc8_d)
`ifdef PC_ALIGN_CHECK_EN
    , .adel_d(adel_d)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_pc_f, m_instr_d, m_pc_d;
  logic        m_adel;

  function automatic bit illegal(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] pf, input logic [31:0] pd,
                                             input logic [31:0] id);
    logic [31:0] off;
    off = {{16{imm16[15]}}, imm16};
    if (id == 32'd0) return pf + 4;
    case (npc_sel)
      2'b01:   return br_taken ? pd + 4 + off * 4 : pf + 4;
      2'b10:   return (pd & 32'hF000_0000) | ({6'd0, instr_index} * 4);
      2'b11:   return rs_val;
      default: return pf + 4;
    endcase
  endfunction

  function automatic logic [31:0] model_fetch(input logic [31:0] pf);
`ifdef PC_ALIGN_CHECK_EN
    if (illegal(pf)) return 32'd0;
`endif
    return imem_word(pf);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc_f <= 32'h3000; m_instr_d <= 32'd0; m_pc_d <= 32'd0; m_adel <= 1'b0;
    end else if (exc_req || eret_req) begin
      m_pc_f <= exc_req ? 32'h4180 : epc;
      m_instr_d <= 32'd0; m_pc_d <= m_pc_f; m_adel <= 1'b0;
    end else if (!stall) begin
      m_pc_f    <= model_next(m_pc_f, m_pc_d, m_instr_d);
      m_instr_d <= model_fetch(m_pc_f);
      m_pc_d    <= m_pc_f;
      m_adel    <= illegal(m_pc_f);
    end
  end

  // Cycle-by-cycle comparison away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("pc_f", pc_f, m_pc_f);
      chk("instr_d", instr_d, m_instr_d);
      chk("pc_d", pc_d, m_pc_d);
      chk("pc8_d", pc8_d, m_pc_d + 8);
`ifdef PC_ALIGN_CHECK_EN
      chk("adel_d", {31'd0, adel_d}, {31'd0, m_adel});
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    started = 1'b1;
    chk("rst_pc_f", pc_f, 32'h3000);
    chk("rst_instr_d", instr_d, 32'd0);
    chk("rst_pc_d", pc_d, 32'd0);
    chk("rst_pc8_d", pc8_d, 32'd8);
    reset = 1'b1;

    // T1 sequential fetch
    tick(); chk("t1_pc_f0", pc_f, 32'h3004); chk("t1_pc_d0", pc_d, 32'h3000);
    tick(); chk("t1_pc_f1", pc_f, 32'h3008); chk("t1_pc8_d", pc8_d, 32'h300C);
    tick(); chk("t1_pc_d2", pc_d, 32'h3008);

    // T2 taken branch backwards, delay slot still enters ID
    npc_sel = 2'b01; br_taken = 1'b1; imm16 = 16'hFFFE;
    tick(); chk("t2_br_pc_f", pc_f, 32'h3004); chk("t2_slot", instr_d, 32'h2400_300C);
    npc_sel = 2'b00;
    tick(); tick(); chk("t2_pc_d", pc_d, 32'h3008);
    npc_sel = 2'b01; br_taken = 1'b0;
    tick(); chk("t2_nt_pc_f", pc_f, 32'h3010);

    // T3 j then jr
    npc_sel = 2'b00;
    tick(); chk("t3_pc_d", pc_d, 32'h3010);
    npc_sel = 2'b10; instr_index = 26'h0000C10;
    tick(); chk("t3_j_pc_f", pc_f, 32'h3040);
    npc_sel = 2'b11; rs_val = 32'h3100;
    tick(); chk("t3_jr_pc_f", pc_f, 32'h3100);

    // T4 stall with pending taken branch (pc_d=0x3040, target 0x3054)
    stall = 1'b1; npc_sel = 2'b01; br_taken = 1'b1; imm16 = 16'h0004;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("t4_hold_pc_f", pc_f, 32'h3100); chk("t4_hold_pc_d", pc_d, 32'h3040);
    end
    stall = 1'b0;
    tick(); chk("t4_rel_pc_f", pc_f, 32'h3054);

    // T5 exception beats stall and eret, then eret
    stall = 1'b1; exc_req = 1'b1; eret_req = 1'b1; epc = 32'h3020; npc_sel = 2'b00;
    tick(); chk("t5_exc_pc_f", pc_f, 32'h4180); chk("t5_exc_instr", instr_d, 32'd0);
    chk("t5_exc_pc_d", pc_d, 32'h3054);
    exc_req = 1'b0; stall = 1'b0;
    tick(); chk("t5_eret_pc_f", pc_f, 32'h3020); chk("t5_eret_pc_d", pc_d, 32'h4180);

    // bubble in ID ignores npc_sel
    eret_req = 1'b0; npc_sel = 2'b10;
    tick(); chk("bubble_pc_f", pc_f, 32'h3024);

    // async reset in the middle of a stalled cycle
    npc_sel = 2'b00; stall = 1'b1;
    #2 reset = 1'b0;
    #1 chk("midrst_pc_f", pc_f, 32'h3000); chk("midrst_pc_d", pc_d, 32'd0);
    tick(); reset = 1'b1; stall = 1'b0;

`ifdef PC_ALIGN_CHECK_EN
    // T6 fetch address errors
    tick();
    npc_sel = 2'b11; rs_val = 32'h3002;
    tick(); chk("t6_pc_f", pc_f, 32'h3002);
    rs_val = 32'h7000;
    tick(); chk("t6_adel_mis", {31'd0, adel_d}, 32'd1); chk("t6_instr0", instr_d, 32'd0);
    chk("t6_pc_d", pc_d, 32'h3002);
    npc_sel = 2'b00;
    tick(); chk("t6_adel_hi", {31'd0, adel_d}, 32'd1);
    eret_req = 1'b1; epc = 32'h3004;
    tick(); chk("t6_adel_clr", {31'd0, adel_d}, 32'd0);
    eret_req = 1'b0;
    tick(); chk("t6_adel_ok", {31'd0, adel_d}, 32'd0); chk("t6_instr_ok", instr_d, 32'h2400_3004);
`endif

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Watchdog: the directed sequence is short; anything longer is a hang.
  initial begin
    #20000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "timeout");
  end
endmodule
